// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, functs, states, ALU codes
// and datapath mux selects.
package mcu_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnSra = 6'b000011;

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSll = 4'b1100;
  localparam logic [3:0] AluSrl = 4'b1101;
  localparam logic [3:0] AluSra = 4'b1111;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  localparam logic [1:0] SrcBReg    = 2'd0;
  localparam logic [1:0] SrcBFour   = 2'd1;
  localparam logic [1:0] SrcBImm    = 2'd2;
  localparam logic [1:0] SrcBImmSh2 = 2'd3;

  typedef enum logic [3:0] {
    StFetch, StFetchWait, StDecode, StMemAdr, StMemRd, StMemRdWait, StMemWb, StMemWr,
    StMemWrWait, StExec, StAluWb, StBranch, StIExec, StIWb, StJump, StTrap
  } state_e;

  function automatic logic is_wait(state_e s);
    return (s == StFetchWait) || (s == StMemRdWait) || (s == StMemWrWait);
  endfunction

endpackage

// File: rtl/mcu_alu_dec.sv
// ALU operation decoder: maps state/opcode/funct to the ALU code and the immediate
// extension select, and flags whether an R-type funct is implemented.
module mcu_alu_dec
  import mcu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  state_e                state,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  imm_zext,
  output logic                  funct_legal
);

  logic [3:0] funct_code;
  logic [3:0] code;

  always_comb begin
    funct_code  = AluAdd;
    funct_legal = 1'b1;
    case (funct)
      FnAdd:   funct_code = AluAdd;
      FnSub:   funct_code = AluSub;
      FnAnd:   funct_code = AluAnd;
      FnOr:    funct_code = AluOr;
      FnSlt:   funct_code = AluSlt;
      FnSll:   funct_code = AluSll;
      FnSrl:   funct_code = AluSrl;
      FnSra:   funct_code = AluSra;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    code     = AluAnd;
    imm_zext = 1'b0;
    case (state)
      StFetchWait, StDecode, StMemAdr: code = AluAdd;
      StExec:   code = funct_code;
      StBranch: code = AluSub;
      StIExec: begin
        case (opcode)
          OpAndi: begin
            code     = AluAnd;
            imm_zext = 1'b1;
          end
          OpOri: begin
            code     = AluOr;
            imm_zext = 1'b1;
          end
          OpSlti:  code = AluSlt;
          default: code = AluAdd;
        endcase
      end
      default: code = AluAnd;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle control unit with request/done memory handshake and illegal-op trap.
// Define MEM_TIMEOUT_EN to add a wait-state watchdog that traps after MEM_TIMEOUT cycles.
module mc_ctrl_unit
  import mcu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_done,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  iord,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  imm_zext,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  reg_dest,
  output logic                  mem_to_reg,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  illegal_op,
  output logic                  mem_timeout
);

  state_e                state_q, state_d;
  logic                  illegal_q, illegal_set;
  logic                  wait_expired;
  logic                  timeout_flag;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic                  dec_imm_zext;
  logic                  funct_legal;

  mcu_alu_dec #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .opcode     (opcode),
    .funct      (funct),
    .state      (state_q),
    .alu_control(dec_alu),
    .imm_zext   (dec_imm_zext),
    .funct_legal(funct_legal)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q;

  // Counter idles at zero outside waits, so it is cleared on every wait entry.
  assign cnt_d        = is_wait(state_q) ? cnt_q + CntW'(1) : '0;
  assign wait_expired = is_wait(state_q) && !mem_done && (cnt_q == CntW'(MEM_TIMEOUT - 1));
  assign timeout_flag = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | wait_expired;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^MEM_TIMEOUT;
  assign wait_expired   = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | illegal_set;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    case (state_q)
      StFetch:     state_d = StFetchWait;
      StFetchWait: if (mem_done) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRtype: begin
            state_d     = funct_legal ? StExec : StTrap;
            illegal_set = !funct_legal;
          end
          OpLw, OpSw:                    state_d = StMemAdr;
          OpBeq, OpBne:                  state_d = StBranch;
          OpAddi, OpSlti, OpAndi, OpOri: state_d = StIExec;
          OpJ:                           state_d = StJump;
          default: begin
            state_d     = StTrap;
            illegal_set = 1'b1;
          end
        endcase
      end
      StMemAdr:    state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:     state_d = StMemRdWait;
      StMemRdWait: if (mem_done) state_d = StMemWb;
      StMemWr:     state_d = StMemWrWait;
      StMemWrWait: if (mem_done) state_d = StFetch;
      StExec:      state_d = StAluWb;
      StIExec:     state_d = StIWb;
      StTrap:      state_d = StTrap;
      default:     state_d = StFetch;
    endcase
    if (wait_expired) state_d = StTrap;
  end

  always_comb begin
    pc_en       = 1'b0;
    pc_src      = PcSrcAlu;
    iord        = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SrcBReg;
    imm_zext    = 1'b0;
    alu_control = dec_alu;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dest    = 1'b0;
    mem_to_reg  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      StFetch: mem_req = 1'b1;
      StFetchWait: begin
        if (mem_done) begin
          ir_write  = 1'b1;
          pc_en     = 1'b1;
          alu_src_b = SrcBFour;
        end else begin
          alu_control = '0;
        end
      end
      StDecode: alu_src_b = SrcBImmSh2;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemRdWait: iord = 1'b1;
      StMemWr: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      StMemWrWait: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StExec: alu_src_a = 1'b1;
      StAluWb: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        imm_zext  = dec_imm_zext;
      end
      StIWb: reg_write = 1'b1;
      StBranch: begin
        pc_src = PcSrcAluOut;
        pc_en  = (opcode == OpBeq) ? zero : ~zero;
      end
      StJump: begin
        pc_src = PcSrcJump;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    illegal_op  = illegal_q;
    mem_timeout = timeout_flag;
    // Reset forces every output low, including the sticky flags.
    if (rst) begin
      pc_en       = 1'b0;
      pc_src      = 2'd0;
      iord        = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'd0;
      imm_zext    = 1'b0;
      alu_control = '0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      reg_dest    = 1'b0;
      mem_to_reg  = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: an instruction-level timeline model plus literal spot checks.
module tb_mc_ctrl_unit;

  localparam int unsigned AW = 5;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a, F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;

  localparam int K_R = 0, K_I = 1, K_MEM = 2, K_BR = 3, K_J = 4, K_ILL = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          mem_done = 1'b0;
  logic          pc_en, iord, alu_src_a, imm_zext, ir_write, reg_write, reg_dest;
  logic          mem_to_reg, mem_req, mem_we, illegal_op, mem_timeout;
  logic [1:0]    pc_src, alu_src_b;
  logic [AW-1:0] alu_control;

  typedef struct packed {
    logic          pc_en;
    logic [1:0]    pc_src;
    logic          iord;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic          imm_zext;
    logic [AW-1:0] alu;
    logic          ir_write, reg_write, reg_dest, mem_to_reg, mem_req, mem_we;
    logic          illegal_op, mem_timeout;
  } outs_t;

  outs_t expq[$];
  outs_t ph_obs[$];
  outs_t last_obs;
  int    tests = 0, fails = 0;
  int    cyc_cnt = 0, last_fetch = 0, fetch_gap = 0, req_total = 0;
  logic  exp_illegal = 1'b0, exp_timeout = 1'b0;

  always #5 clk = ~clk;

  mc_ctrl_unit #(.ALU_CTRL_W(AW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_done(mem_done),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_control(alu_control),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .mem_req(mem_req), .mem_we(mem_we),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  function automatic outs_t observe();
    outs_t o;
    o.pc_en = pc_en; o.pc_src = pc_src; o.iord = iord; o.alu_src_a = alu_src_a;
    o.alu_src_b = alu_src_b; o.imm_zext = imm_zext; o.alu = alu_control;
    o.ir_write = ir_write; o.reg_write = reg_write; o.reg_dest = reg_dest;
    o.mem_to_reg = mem_to_reg; o.mem_req = mem_req; o.mem_we = mem_we;
    o.illegal_op = illegal_op; o.mem_timeout = mem_timeout;
    return o;
  endfunction

  // Single compare process: one expected entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    outs_t obs, e;
    obs = observe();
    last_obs = obs;
    cyc_cnt++;
    if (obs.mem_req === 1'b1) begin
      req_total++;
      if (obs.iord === 1'b0) begin
        fetch_gap  = cyc_cnt - last_fetch;
        last_fetch = cyc_cnt;
      end
    end
    if (expq.size() != 0) begin
      e = expq.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got %h, expected %h", cyc_cnt, obs, e);
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic cyc(input outs_t e, input logic done);
    mem_done = done;
    expq.push_back(e);
    @(posedge clk);
    #1;
    ph_obs.push_back(last_obs);
  endtask

  function automatic outs_t base();
    outs_t o = '0;
    o.illegal_op  = exp_illegal;
    o.mem_timeout = exp_timeout;
    return o;
  endfunction

  function automatic outs_t o_fetch();
    outs_t o = base();
    o.mem_req = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_fetch_wait(input logic done);
    outs_t o = base();
    if (done) begin
      o.ir_write = 1'b1; o.pc_en = 1'b1; o.alu_src_b = 2'd1; o.alu = AW'(4'b0010);
    end
    return o;
  endfunction

  function automatic outs_t o_decode();
    outs_t o = base();
    o.alu_src_b = 2'd3;
    o.alu = AW'(4'b0010);
    return o;
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R) begin
      case (fn)
        F_ADD: return 4'b0010;
        F_SUB: return 4'b0110;
        F_AND: return 4'b0000;
        F_OR:  return 4'b0001;
        F_SLT: return 4'b0111;
        F_SLL: return 4'b1100;
        F_SRL: return 4'b1101;
        F_SRA: return 4'b1111;
        default: return 4'b0000;
      endcase
    end
    case (op)
      OP_ANDI:        return 4'b0000;
      OP_ORI:         return 4'b0001;
      OP_SLTI:        return 4'b0111;
      OP_BEQ, OP_BNE: return 4'b0110;
      default:        return 4'b0010;
    endcase
  endfunction

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R: return (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_SRA}) ? K_R : K_ILL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return K_I;
      OP_LW, OP_SW:   return K_MEM;
      OP_BEQ, OP_BNE: return K_BR;
      OP_J:           return K_J;
      default:        return K_ILL;
    endcase
  endfunction

  // Builds the whole expected timeline of one instruction and drives its handshake.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int lat,
                           input logic z, input logic early, input logic skip_fetch);
    outs_t o;
    opcode = op; funct = fn; zero = z;
    ph_obs.delete();
    if (!skip_fetch) cyc(o_fetch(), early);
    for (int i = 1; i <= lat; i++) cyc(o_fetch_wait(i == lat), i == lat);
    cyc(o_decode(), 1'b0);
    case (kind(op, fn))
      K_R: begin
        o = base(); o.alu_src_a = 1'b1; o.alu = AW'(alu_of(op, fn)); cyc(o, 1'b0);
        o = base(); o.reg_write = 1'b1; o.reg_dest = 1'b1; cyc(o, 1'b0);
      end
      K_I: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu = AW'(alu_of(op, fn));
        o.imm_zext = (op == OP_ANDI) || (op == OP_ORI);
        cyc(o, 1'b0);
        o = base(); o.reg_write = 1'b1; cyc(o, 1'b0);
      end
      K_MEM: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu = AW'(4'b0010); cyc(o, 1'b0);
        o = base(); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == OP_SW); cyc(o, early);
        o.mem_req = 1'b0;
        for (int i = 1; i <= lat; i++) cyc(o, i == lat);
        if (op == OP_LW) begin
          o = base(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1; cyc(o, 1'b0);
        end
      end
      K_BR: begin
        o = base(); o.alu = AW'(4'b0110); o.pc_src = 2'd1;
        o.pc_en = (op == OP_BEQ) ? z : !z;
        cyc(o, 1'b0);
      end
      K_J: begin
        o = base(); o.pc_src = 2'd2; o.pc_en = 1'b1; cyc(o, 1'b0);
      end
      default: begin
        exp_illegal = 1'b1;
        for (int i = 0; i < 3; i++) cyc(base(), i[0]);
      end
    endcase
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_illegal = 1'b0;
    exp_timeout = 1'b0;
    for (int i = 0; i < n; i++) cyc(base(), 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int    r0;
    outs_t o;
    logic [5:0] rfn[6] = '{F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_SRA};
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(OP_R, F_ADD, 1, 1'b0, 1'b0, 1'b0);
    lit("add_first_req", int'(ph_obs[0].mem_req), 1);
    lit("add_alu_code", int'(ph_obs[3].alu), 2);
    lit("add_wb_only", int'({ph_obs[4].reg_write, ph_obs[4].reg_dest, ph_obs[3].reg_write}), 6);
    run_instr(OP_R, F_SUB, 2, 1'b0, 1'b1, 1'b0);
    lit("add_cycles", fetch_gap, 5);

    r0 = req_total;
    run_instr(OP_LW, 6'h00, 3, 1'b0, 1'b0, 1'b0);
    lit("lw_req_pulses", req_total - r0, 2);
    lit("lw_data_req", int'({ph_obs[6].mem_req, ph_obs[6].iord, ph_obs[6].mem_we}), 6);
    lit("lw_mem_to_reg", int'(ph_obs[10].mem_to_reg), 1);
    run_instr(OP_SW, 6'h00, 2, 1'b1, 1'b1, 1'b0);

    run_instr(OP_ADDI, 6'h11, 1, 1'b0, 1'b0, 1'b0);
    run_instr(OP_SLTI, 6'h00, 2, 1'b0, 1'b0, 1'b0);
    run_instr(OP_ANDI, 6'h00, 1, 1'b0, 1'b0, 1'b0);
    lit("andi_zext_and", int'({ph_obs[3].imm_zext, ph_obs[3].alu}), 32);
    run_instr(OP_ORI, 6'h00, 3, 1'b0, 1'b0, 1'b0);
    foreach (rfn[i]) run_instr(OP_R, rfn[i], 1 + (i % 2), 1'b0, 1'b0, 1'b0);

    run_instr(OP_BEQ, 6'h00, 1, 1'b1, 1'b0, 1'b0);
    run_instr(OP_BEQ, 6'h00, 1, 1'b0, 1'b0, 1'b0);
    run_instr(OP_BNE, 6'h00, 1, 1'b0, 1'b0, 1'b0);
    lit("bne_taken", int'({ph_obs[3].pc_en, ph_obs[3].pc_src}), 5);
    run_instr(OP_BNE, 6'h00, 1, 1'b1, 1'b0, 1'b0);
    lit("bne_not_taken", int'(ph_obs[3].pc_en), 0);
    run_instr(OP_J, 6'h00, 1, 1'b0, 1'b0, 1'b0);

`ifdef MEM_TIMEOUT_EN
    opcode = OP_ADDI; funct = 6'h00;
    cyc(o_fetch(), 1'b0);
    for (int i = 0; i < 4; i++) cyc(o_fetch_wait(1'b0), 1'b0);
    exp_timeout = 1'b1;
    cyc(base(), 1'b0);
    cyc(base(), 1'b1);
    lit("timeout_flag", int'(last_obs.mem_timeout), 1);
    do_reset(1);
    run_instr(OP_ADDI, 6'h00, 4, 1'b0, 1'b0, 1'b0);
    lit("done_on_last_wait", int'(last_obs.mem_timeout), 0);
`else
    run_instr(OP_ADDI, 6'h00, 6, 1'b0, 1'b0, 1'b0);
    lit("long_wait_no_trap", int'(last_obs.mem_timeout), 0);
`endif

    // Reset while waiting on a store, then the stale done arrives.
    opcode = OP_SW; funct = 6'h00;
    cyc(o_fetch(), 1'b0);
    cyc(o_fetch_wait(1'b1), 1'b1);
    cyc(o_decode(), 1'b0);
    o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu = AW'(4'b0010); cyc(o, 1'b0);
    o = base(); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = 1'b1; cyc(o, 1'b0);
    o.mem_req = 1'b0; cyc(o, 1'b0);
    do_reset(1);
    cyc(o_fetch(), 1'b1);
    lit("rst_wait_fetch_req", int'(last_obs.mem_req), 1);
    run_instr(OP_R, F_ADD, 1, 1'b0, 1'b0, 1'b1);

    run_instr(6'b111111, 6'h00, 1, 1'b0, 1'b0, 1'b0);
    lit("trap_illegal", int'(last_obs.illegal_op), 1);
    lit("trap_no_req", int'(last_obs.mem_req), 0);
    do_reset(1);
    run_instr(OP_R, F_ADD, 1, 1'b0, 1'b0, 1'b0);
    lit("post_trap_req", int'(ph_obs[0].mem_req), 1);

    run_instr(OP_R, 6'h3f, 2, 1'b0, 1'b0, 1'b0);
    lit("bad_funct_trap", int'(last_obs.illegal_op), 1);
    do_reset(1);
    run_instr(OP_ORI, 6'h00, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
